pipeline_regs: RTL and testbench
================================

// Module: pipeline_regs
// PURPOSE
//  Holds the four inter-stage registers (F/D, D/E, E/M, M/W) of the 5-stage ARMv3 pipeline.
//  Consumes StallF/StallD/FlushD/FlushE from the hazard unit.
//  Produces the RA1E/RA2E/WA3E/WA3M/WA3W/RA2M and RegWrite*/MemtoReg*/MemWriteM inputs the hazard unit needs.
//  Tracks per-stage valid bits and a saturating bubble counter for performance debug.
// PARAMETERS
//  CTRL_W  16  width of decoded control bundle CtrlD/CtrlE (bit map in pipe_pkg)
//  CNT_W   16  width of BubbleCount
// PORTS
//  CLK        in   1       clock, rising edge
//  Reset      in   1       asynchronous, active-high; clears every register
//  StallD     in   1       hold F/D register
//  FlushD     in   1       kill F/D contents
//  FlushE     in   1       kill D/E contents
//  InstrF     in   32      fetched instruction
//  PCPlus4F   in   32      fetch PC+4 (becomes PCPlus8D)
//  InstrD     out  32      decode instruction
//  PCPlus8D   out  32      PC+8 for R15 reads
//  ValidD     out  1       D holds a real instruction
//  RD1D/RD2D  in   32 ea   register-file read data
//  ExtImmD    in   32      extended immediate
//  RA1D/RA2D/WA3D  in  4 ea  source/dest register numbers
//  CtrlD      in   CTRL_W  decoded control bundle
//  RD1E/RD2E/ExtImmE  out  32 ea  E operands
//  RA1E/RA2E/WA3E     out  4 ea   E register numbers
//  CtrlE      out  CTRL_W  E control bundle
//  ValidE     out  1       E holds a real instruction
//  ALUResultE/WriteDataE  in  32 ea  E results
//  RegWriteGE/MemWriteGE  in  1 ea   condition-gated writes from E
//  ALUResultM/WriteDataM  out  32 ea
//  RA2M/WA3M  out  4 ea
//  RegWriteM/MemtoRegM/MemWriteM  out  1 ea
//  ReadDataM  in   32      data-memory read data
//  ReadDataW/ALUOutW  out  32 ea
//  WA3W       out  4
//  RegWriteW/MemtoRegW  out  1 ea
//  BubbleCount  out  CNT_W  cycles with ValidE==0, saturating
// BEHAVIOUR
//  Reset (async, any time): every output 0, including valids and BubbleCount.
//    Pipeline restarts cleanly on the next edge after deassert.
//  F/D, per rising edge:
//    - FlushD=1: InstrD=0, PCPlus8D=0, ValidD=0. FlushD beats StallD (wrong-path kill).
//    - else StallD=1: hold all F/D state.
//    - else load InstrF/PCPlus4F and set ValidD=1.
//  StallF is handled by the fetch PC register, not here.
//  D/E:
//    - FlushE=1: all fields 0, ValidE=0.
//    - else load D fields; CtrlE = ValidD ? CtrlD : 0 (an invalid D never writes).
//    - ValidE = ValidD.
//    - Ld-use stall (StallD & FlushE together): D holds while E gets the bubble.
//  E/M: always advances. RegWriteM=RegWriteGE&ValidE, MemWriteM=MemWriteGE&ValidE,
//    MemtoRegM=CtrlE[MEMTOREG]&ValidE. RA2M<=RA2E, WA3M<=WA3E.
//  M/W: always advances; RegWriteW/MemtoRegW/WA3W/ALUOutW copied from M, ReadDataW<=ReadDataM.
//  Latency: exactly 1 cycle per stage; no combinational input->output paths.
//  BubbleCount: +1 each edge where ValidE==0 after the update; holds at 2^CNT_W-1.
//  X on StallD/FlushD/FlushE is not permitted; assertion in sim.
// STRUCTURE
//  pipe_pkg: CTRL_W bit positions (REGWRITE=0, MEMTOREG=1, MEMWRITE=2, BRANCH=3,
//    ALUCTL=7:4, FLAGW=9:8, COND=13:10, ALUSRC=14, PCS=15) and NOP/zero constants.
//  Sub-module pipe_stage_reg #(W): async-reset flop with en and synchronous clr (clr > en);
//    instantiated once per stage.
// TESTING
//  1. Reset mid-stream: assert Reset between edges -> all outputs 0 immediately; BubbleCount=0.
//  2. Straight-line: 4 instrs, no hazards -> InstrF appears at InstrD +1, WA3W +4; ValidE=1 steady.
//  3. Ld-use: StallD=1, FlushE=1 for 1 cycle -> InstrD held, CtrlE=0, ValidE=0, BubbleCount+1, RegWriteM=0 next edge.
//  4. Branch with stall (StallD=FlushD=FlushE=1) -> InstrD=0, ValidD=0, ValidE=0; two bubbles counted.
//  5. Condition fail: RegWriteGE=0, MemWriteGE=0 with ValidE=1 -> RegWriteM=0, MemWriteM=0.
//  6. Counter saturation with CNT_W=4: 20 flush cycles -> BubbleCount=15, stays 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared constants for the 5-stage ARMv3 pipeline registers.
//   This package has no ports. It holds:
//     - bit positions inside the decoded control bundle (CtrlD/CtrlE)
//     - NOP/zero constants used when a stage is killed or reset
package pipe_pkg;

    // Control bundle bit map (CTRL_W must be at least PCS+1)
    localparam int REGWRITE  = 0;
    localparam int MEMTOREG  = 1;
    localparam int MEMWRITE  = 2;
    localparam int BRANCH    = 3;
    localparam int ALUCTL_LO = 4;
    localparam int ALUCTL_HI = 7;
    localparam int FLAGW_LO  = 8;
    localparam int FLAGW_HI  = 9;
    localparam int COND_LO   = 10;
    localparam int COND_HI   = 13;
    localparam int ALUSRC    = 14;
    localparam int PCS       = 15;

    // A killed F/D slot reads back as an all-zero instruction
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline stage register: asynchronous active-high reset,
//   load enable, and synchronous clear. Clear has priority over enable,
//   so a flush still kills the stage while it is stalled.
// Ports
//   CLK    in  1   clock, rising edge
//   Reset  in  1   asynchronous, active-high; clears q
//   en     in  1   load d on the next edge
//   clr    in  1   synchronous clear (wins over en)
//   d      in  W   next-stage contents
//   q      out W   registered contents
module pipe_stage_reg #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_regs.sv
// pipeline_regs
//   The four inter-stage registers (F/D, D/E, E/M, M/W) of the 5-stage
//   ARMv3 pipeline, per-stage valid bits, and a saturating counter of
//   cycles in which E holds a bubble.
// Ports
//   CLK, Reset                         clock / async active-high reset
//   StallD, FlushD, FlushE             hazard-unit controls
//   InstrF, PCPlus4F                   fetch outputs
//   InstrD, PCPlus8D, ValidD           decode-stage registers
//   RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D, CtrlD   decode results
//   RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E, CtrlE, ValidE   execute registers
//   ALUResultE, WriteDataE, RegWriteGE, MemWriteGE  execute results
//   ALUResultM, WriteDataM, RA2M, WA3M, RegWriteM, MemtoRegM, MemWriteM
//   ReadDataM                          data-memory read data
//   ReadDataW, ALUOutW, WA3W, RegWriteW, MemtoRegW  writeback registers
//   BubbleCount                        cycles with ValidE==0, saturating
module pipeline_regs
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCPlus8D,
    output logic              ValidD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ExtImmD,
    input  logic [3:0]        RA1D,
    input  logic [3:0]        RA2D,
    input  logic [3:0]        WA3D,
    input  logic [CTRL_W-1:0] CtrlD,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ExtImmE,
    output logic [3:0]        RA1E,
    output logic [3:0]        RA2E,
    output logic [3:0]        WA3E,
    output logic [CTRL_W-1:0] CtrlE,
    output logic              ValidE,
    input  logic [31:0]       ALUResultE,
    input  logic [31:0]       WriteDataE,
    input  logic              RegWriteGE,
    input  logic              MemWriteGE,
    output logic [31:0]       ALUResultM,
    output logic [31:0]       WriteDataM,
    output logic [3:0]        RA2M,
    output logic [3:0]        WA3M,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    input  logic [31:0]       ReadDataM,
    output logic [31:0]       ReadDataW,
    output logic [31:0]       ALUOutW,
    output logic [3:0]        WA3W,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [CNT_W-1:0]  BubbleCount
);

    localparam int FD_W = 32 + 32 + 1;
    localparam int DE_W = 3 * 32 + 3 * 4 + CTRL_W + 1;
    localparam int EM_W = 2 * 32 + 2 * 4 + 3;
    localparam int MW_W = 2 * 32 + 4 + 2;

    logic [FD_W-1:0]   fd_d, fd_q;
    logic [DE_W-1:0]   de_d, de_q;
    logic [EM_W-1:0]   em_d, em_q;
    logic [MW_W-1:0]   mw_d, mw_q;
    logic [CTRL_W-1:0] ctrl_gated;
    logic              valid_e_next;

    // F/D: FlushD beats StallD so a wrong-path fetch dies even while held
    assign fd_d = {InstrF, PCPlus4F, 1'b1};

    pipe_stage_reg #(.W(FD_W)) u_fd (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (~StallD),
        .clr   (FlushD),
        .d     (fd_d),
        .q     (fd_q)
    );

    assign {InstrD, PCPlus8D, ValidD} = fd_q;

    // An invalid decode slot must never carry write enables into E
    assign ctrl_gated = ValidD ? CtrlD : '0;
    assign de_d = {RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D, ctrl_gated, ValidD};

    pipe_stage_reg #(.W(DE_W)) u_de (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (de_d),
        .q     (de_q)
    );

    assign {RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E, CtrlE, ValidE} = de_q;

    assign em_d = {ALUResultE, WriteDataE, RA2E, WA3E,
                   RegWriteGE & ValidE,
                   CtrlE[MEMTOREG] & ValidE,
                   MemWriteGE & ValidE};

    pipe_stage_reg #(.W(EM_W)) u_em (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (em_d),
        .q     (em_q)
    );

    assign {ALUResultM, WriteDataM, RA2M, WA3M, RegWriteM, MemtoRegM, MemWriteM} = em_q;

    assign mw_d = {ReadDataM, ALUResultM, WA3M, RegWriteM, MemtoRegM};

    pipe_stage_reg #(.W(MW_W)) u_mw (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (mw_d),
        .q     (mw_q)
    );

    assign {ReadDataW, ALUOutW, WA3W, RegWriteW, MemtoRegW} = mw_q;

    // Count against the value ValidE takes at this edge, not the old one
    assign valid_e_next = ~FlushE & ValidD;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            BubbleCount <= '0;
        end else if (!valid_e_next && (BubbleCount != {CNT_W{1'b1}})) begin
            BubbleCount <= BubbleCount + 1'b1;
        end
    end

    a_ctrl_known : assert property (@(posedge CLK) disable iff (Reset)
        !$isunknown({StallD, FlushD, FlushE}));

endmodule

// File: tb/tb_pipeline_regs.sv
module tb_pipeline_regs;
    import pipe_pkg::*;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        StallD, FlushD, FlushE;
    logic [31:0] InstrF, PCPlus4F;
    logic [31:0] InstrD, PCPlus8D;
    logic        ValidD;
    logic [31:0] RD1D, RD2D, ExtImmD;
    logic [3:0]  RA1D, RA2D, WA3D;
    logic [15:0] CtrlD;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [3:0]  RA1E, RA2E, WA3E;
    logic [15:0] CtrlE;
    logic        ValidE;
    logic [31:0] ALUResultE, WriteDataE;
    logic        RegWriteGE, MemWriteGE;
    logic [31:0] ALUResultM, WriteDataM;
    logic [3:0]  RA2M, WA3M;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ReadDataM;
    logic [31:0] ReadDataW, ALUOutW;
    logic [3:0]  WA3W;
    logic        RegWriteW, MemtoRegW;
    logic [CNT_W-1:0] BubbleCount;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_regs #(.CTRL_W(16), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .CtrlD(CtrlD),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .CtrlE(CtrlE), .ValidE(ValidE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RA2M(RA2M), .WA3M(WA3M),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ReadDataM(ReadDataM),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .BubbleCount(BubbleCount)
    );

    always #5 CLK = ~CLK;

    // Reference model: one record per pipeline slot
    typedef struct {
        logic [31:0] instr, pc8;
        logic        v;
    } fd_t;
    typedef struct {
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  ra1, ra2, wa3;
        logic [15:0] ctrl;
        logic        v;
    } de_t;
    typedef struct {
        logic [31:0] alu, wd;
        logic [3:0]  ra2, wa3;
        logic        rw, mtr, mw;
    } em_t;
    typedef struct {
        logic [31:0] rd, alu;
        logic [3:0]  wa3;
        logic        rw, mtr;
    } mw_t;

    fd_t m_fd;
    de_t m_de;
    em_t m_em;
    mw_t m_mw;
    int  m_bub;

    task automatic model_clear();
        m_fd = '{32'h0, 32'h0, 1'b0};
        m_de = '{32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0};
        m_em = '{32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        m_mw = '{32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
        m_bub = 0;
    endtask

    // Advance every slot by one instruction, oldest stage first
    task automatic model_step();
        m_mw.rd  = ReadDataM;
        m_mw.alu = m_em.alu;
        m_mw.wa3 = m_em.wa3;
        m_mw.rw  = m_em.rw;
        m_mw.mtr = m_em.mtr;

        m_em.alu = ALUResultE;
        m_em.wd  = WriteDataE;
        m_em.ra2 = m_de.ra2;
        m_em.wa3 = m_de.wa3;
        m_em.rw  = RegWriteGE && m_de.v;
        m_em.mw  = MemWriteGE && m_de.v;
        m_em.mtr = m_de.ctrl[MEMTOREG] && m_de.v;

        if (FlushE)
            m_de = '{32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0};
        else
            m_de = '{RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
                     (m_fd.v ? CtrlD : 16'h0), m_fd.v};

        if (FlushD)
            m_fd = '{32'h0, 32'h0, 1'b0};
        else if (!StallD)
            m_fd = '{InstrF, PCPlus4F, 1'b1};

        if (!m_de.v && m_bub < CNT_MAX)
            m_bub = m_bub + 1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("fd", {InstrD, PCPlus8D, ValidD}, {m_fd.instr, m_fd.pc8, m_fd.v});
        check("de", {RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E, CtrlE, ValidE},
              {m_de.rd1, m_de.rd2, m_de.imm, m_de.ra1, m_de.ra2, m_de.wa3, m_de.ctrl, m_de.v});
        check("em", {ALUResultM, WriteDataM, RA2M, WA3M, RegWriteM, MemtoRegM, MemWriteM},
              {m_em.alu, m_em.wd, m_em.ra2, m_em.wa3, m_em.rw, m_em.mtr, m_em.mw});
        check("mw", {ReadDataW, ALUOutW, WA3W, RegWriteW, MemtoRegW},
              {m_mw.rd, m_mw.alu, m_mw.wa3, m_mw.rw, m_mw.mtr});
        check("bubble", 256'(BubbleCount), 256'(m_bub));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
    endtask

    // Called at posedge+1: reset asserts between edges and releases before the next one
    task automatic pulse_reset();
        #2 Reset = 1'b1;
        model_clear();
        #1;
        check_all();
        check("bubble_after_reset", 256'(BubbleCount), 256'(0));
        check("valids_after_reset", {ValidD, ValidE}, 2'b00);
        #1 Reset = 1'b0;
    endtask

    task automatic rand_data();
        InstrF     = $urandom;
        PCPlus4F   = $urandom;
        RD1D       = $urandom;
        RD2D       = $urandom;
        ExtImmD    = $urandom;
        RA1D       = 4'($urandom);
        RA2D       = 4'($urandom);
        WA3D       = 4'($urandom);
        CtrlD      = 16'($urandom);
        ALUResultE = $urandom;
        WriteDataE = $urandom;
        RegWriteGE = 1'($urandom);
        MemWriteGE = 1'($urandom);
        ReadDataM  = $urandom;
    endtask

    typedef struct {
        logic        stall_d, flush_d, flush_e;
        logic [31:0] instr;
        logic [31:0] exp_instr_d;
        logic        exp_vd, exp_ve;
        int          exp_bub;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'hA1, 32'hA1, 1'b1, 1'b0, 1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'hA2, 32'hA2, 1'b1, 1'b1, 1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'hA3, 32'hA3, 1'b1, 1'b1, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'hA4, 32'hA3, 1'b1, 1'b0, 2};  // load-use
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'hA4, 32'hA4, 1'b1, 1'b1, 2};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'hA5, 32'h0,  1'b0, 1'b0, 3};  // branch + stall
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'hA6, 32'hA6, 1'b1, 1'b0, 4};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'hA7, 32'hA7, 1'b1, 1'b1, 4};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'hA8, 32'hA7, 1'b1, 1'b1, 4};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'hA9, 32'hA9, 1'b1, 1'b0, 5};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'hAA, 32'hAA, 1'b1, 1'b1, 5};

        Reset = 1'b1;
        StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
        InstrF = 0; PCPlus4F = 0; RD1D = 0; RD2D = 0; ExtImmD = 0;
        RA1D = 0; RA2D = 0; WA3D = 0; CtrlD = 0;
        ALUResultE = 0; WriteDataE = 0; RegWriteGE = 0; MemWriteGE = 0; ReadDataM = 0;
        model_clear();
        #2;
        check_all();
        #1 Reset = 1'b0;

        // Directed hazard sequence
        for (int i = 0; i < 11; i++) begin
            StallD   = vecs[i].stall_d;
            FlushD   = vecs[i].flush_d;
            FlushE   = vecs[i].flush_e;
            InstrF   = vecs[i].instr;
            PCPlus4F = vecs[i].instr + 32'd4;
            WA3D     = 4'(i);
            CtrlD    = 16'hFFFF;
            RegWriteGE = 1'b1;
            MemWriteGE = 1'b1;
            tick();
            check($sformatf("vec%0d_instr_d", i), 256'(InstrD), 256'(vecs[i].exp_instr_d));
            check($sformatf("vec%0d_valid_d", i), 256'(ValidD), 256'(vecs[i].exp_vd));
            check($sformatf("vec%0d_valid_e", i), 256'(ValidE), 256'(vecs[i].exp_ve));
            check($sformatf("vec%0d_bubble", i), 256'(BubbleCount), 256'(vecs[i].exp_bub));
            if (!vecs[i].exp_ve)
                check($sformatf("vec%0d_ctrl_e_zero", i), 256'(CtrlE), 256'(0));
        end
        // Instr entered at vec8 slot (WA3D=7 then) held; WA3D=10 decoded last
        // Condition-failed instruction in E must not write
        StallD = 0; FlushD = 0; FlushE = 0;
        RegWriteGE = 1'b0; MemWriteGE = 1'b0;
        tick();
        check("cond_fail_regwrite_m", 256'(RegWriteM), 256'(0));
        check("cond_fail_memwrite_m", 256'(MemWriteM), 256'(0));
        RegWriteGE = 1'b1; MemWriteGE = 1'b1;
        tick();
        check("cond_pass_regwrite_m", 256'(RegWriteM), 256'(1));
        check("cond_pass_memwrite_m", 256'(MemWriteM), 256'(1));

        // Write address reaches W three edges after D
        WA3D = 4'hC;
        tick();
        WA3D = 4'h3;
        tick();
        tick();
        check("wa3_latency", 256'(WA3W), 256'(4'hC));

        // Randomized traffic with a reset in the middle
        for (int c = 0; c < 300; c++) begin
            rand_data();
            StallD = ($urandom_range(0, 4) == 0);
            FlushD = ($urandom_range(0, 7) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            tick();
            if (c == 150) pulse_reset();
        end

        // Saturation of the 4-bit counter
        StallD = 0; FlushD = 0; FlushE = 0;
        tick();
        pulse_reset();
        FlushE = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            rand_data();
            tick();
            if (c == 15) check("bubble_reaches_max", 256'(BubbleCount), 256'(15));
        end
        check("bubble_stays_max", 256'(BubbleCount), 256'(15));
        FlushE = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
